// File: rtl/lcd_pkg.sv
// Shared mode encodings, RGB565 colour constants and small helpers for the
// LCD pattern generator.
package lcd_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_GRID   = 2'd1,
        MODE_GRAD   = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t WHITE   = 16'hFFFF;
    localparam rgb565_t YELLOW  = 16'hFFE0;
    localparam rgb565_t CYAN    = 16'h07FF;
    localparam rgb565_t GREEN   = 16'h07E0;
    localparam rgb565_t MAGENTA = 16'hF81F;
    localparam rgb565_t RED     = 16'hF800;
    localparam rgb565_t BLUE    = 16'h001F;
    localparam rgb565_t BLACK   = 16'h0000;

    function automatic rgb565_t bar_colour(input logic [2:0] idx);
        rgb565_t c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Timing-generator inputs and panel outputs of the pattern generator.
// The timing side (or a bench) uses master; the pattern generator uses slave.
interface lcd_pattern_gen_if;
    import lcd_pkg::*;

    logic               HSYNC_IN;
    logic               VSYNC_IN;
    logic               DEN_IN;
    logic [COORD_W-1:0] X_IN;
    logic [COORD_W-1:0] Y_IN;

    logic               LCD_HSYNC;
    logic               LCD_VSYNC;
    logic               LCD_DEN;
    logic [4:0]         LCD_R;
    logic [5:0]         LCD_G;
    logic [4:0]         LCD_B;
    logic [1:0]         MODE;

    modport master (
        output HSYNC_IN, VSYNC_IN, DEN_IN, X_IN, Y_IN,
        input  LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B, MODE
    );

    modport slave (
        input  HSYNC_IN, VSYNC_IN, DEN_IN, X_IN, Y_IN,
        output LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B, MODE
    );

endinterface

// File: rtl/lcd_pattern_gen_btn_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low button;
// emits a one-cycle PRESS pulse when a new low level is accepted.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic CLK,
    input  logic RST_IN,
    input  logic BTN_N,
    output logic PRESS
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          sync_prev_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;

    // cnt_reg holds the stable cycles seen since the last change of sync2_reg
    assign accept = (sync2_reg == sync_prev_reg) && (sync2_reg != level_reg) &&
                    (cnt_reg == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            sync_prev_reg <= 1'b1;
            level_reg     <= 1'b1;
            press_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            sync1_reg     <= BTN_N;
            sync2_reg     <= sync1_reg;
            sync_prev_reg <= sync2_reg;
            if (sync2_reg != sync_prev_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (accept) begin
                level_reg <= sync2_reg;
            end
            press_reg <= accept && !sync2_reg;
        end
    end

    assign PRESS = press_reg;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern source behind the LCD timing generator: four patterns,
// button/auto mode selection, and a 2-cycle pipeline keeping syncs aligned.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int LCD_WIDTH       = 480,
    parameter int LCD_HEIGHT      = 280,
    parameter int BOX_SIZE        = 32,
    parameter int AUTO_FRAMES     = 120,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic              CLK,
    input  logic              RST_IN,
    input  logic              BTN_N,
    lcd_pattern_gen_if.slave  lcd
);

    localparam int BW = LCD_WIDTH / 8;
    localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [AW-1:0]      AUTO_LAST = AW'(AUTO_FRAMES - 1);
    localparam logic [COORD_W:0]   X_LIMIT   = (COORD_W + 1)'(LCD_WIDTH - 1);
    localparam logic [COORD_W:0]   Y_LIMIT   = (COORD_W + 1)'(LCD_HEIGHT - 1);
    localparam logic [COORD_W:0]   BOX_EXT   = (COORD_W + 1)'(BOX_SIZE);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(LCD_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(LCD_HEIGHT - 1);

    genvar gi;

    logic vsync_d_reg;
    logic frame_tick;
    logic press;

    // vsync_d_reg resets high so releasing reset never fakes a rising edge
    assign frame_tick = lcd.VSYNC_IN && !vsync_d_reg;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .CLK    (CLK),
        .RST_IN (RST_IN),
        .BTN_N  (BTN_N),
        .PRESS  (press)
    );

    mode_t         mode_reg, mode_next;
    logic          pending_reg, pending_next;
    logic [AW-1:0] auto_cnt_reg, auto_cnt_next;
    logic          auto_hit;
    logic          advance;

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            mode_reg     <= MODE_BARS;
            pending_reg  <= 1'b0;
            auto_cnt_reg <= '0;
        end else begin
            mode_reg     <= mode_next;
            pending_reg  <= pending_next;
            auto_cnt_reg <= auto_cnt_next;
        end
    end

    // Requests only take effect on a tick, so the picture never tears
    always_comb begin
        auto_hit      = (AUTO_FRAMES != 0) && frame_tick && (auto_cnt_reg == AUTO_LAST);
        advance       = frame_tick && (pending_reg || press || auto_hit);
        mode_next     = mode_reg;
        pending_next  = pending_reg;
        auto_cnt_next = auto_cnt_reg;
        if (advance) begin
            mode_next     = next_mode(mode_reg);
            pending_next  = 1'b0;
            auto_cnt_next = '0;
        end else begin
            if (press) begin
                pending_next = 1'b1;
            end
            if (frame_tick && (AUTO_FRAMES != 0)) begin
                auto_cnt_next = auto_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        lcd.MODE = mode_reg;
    end

    logic [7:0]         frame_cnt_reg;
    logic [COORD_W-1:0] bx_reg, by_reg, bx_next, by_next;
    logic               dx_reg, dy_reg, dx_next, dy_next;
    logic               unused_frame_bits;

    assign unused_frame_bits = ^frame_cnt_reg[7:5];

    // Direction 1 means increasing; the reversed direction applies to this tick's step
    always_comb begin
        dx_next = dx_reg ? (({1'b0, bx_reg} + BOX_EXT) < X_LIMIT) : (bx_reg <= 11'd1);
        dy_next = dy_reg ? (({1'b0, by_reg} + BOX_EXT) < Y_LIMIT) : (by_reg <= 11'd1);
        bx_next = dx_next ? bx_reg + 1'b1 : bx_reg - 1'b1;
        by_next = dy_next ? by_reg + 1'b1 : by_reg - 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            vsync_d_reg   <= 1'b1;
            frame_cnt_reg <= '0;
            bx_reg        <= '0;
            by_reg        <= '0;
            dx_reg        <= 1'b1;
            dy_reg        <= 1'b1;
        end else begin
            vsync_d_reg <= lcd.VSYNC_IN;
            if (frame_tick) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
                bx_reg        <= bx_next;
                by_reg        <= by_next;
                dx_reg        <= dx_next;
                dy_reg        <= dy_next;
            end
        end
    end

    logic [7:1] bar_ge;
    logic [2:0] bar_idx;

    generate
        for (gi = 1; gi < 8; gi++) begin : g_bar_cmp
            assign bar_ge[gi] = (lcd.X_IN >= COORD_W'(gi * BW));
        end
    endgenerate

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (bar_ge[k]) begin
                bar_idx = 3'(k);
            end
        end
    end

    logic grid_hit, box_hit;

    assign grid_hit = (lcd.X_IN[4:0] == 5'd0) || (lcd.Y_IN[4:0] == 5'd0) ||
                      (lcd.X_IN == X_LAST) || (lcd.Y_IN == Y_LAST);
    assign box_hit  = (lcd.X_IN >= bx_reg) && ({1'b0, lcd.X_IN} < ({1'b0, bx_reg} + BOX_EXT)) &&
                      (lcd.Y_IN >= by_reg) && ({1'b0, lcd.Y_IN} < ({1'b0, by_reg} + BOX_EXT));

    logic    hs_s1_reg, vs_s1_reg, de_s1_reg;
    mode_t   mode_s1_reg;
    logic [2:0] bar_s1_reg;
    logic    grid_s1_reg, box_s1_reg;
    rgb565_t grad_s1_reg;

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            hs_s1_reg   <= 1'b1;
            vs_s1_reg   <= 1'b1;
            de_s1_reg   <= 1'b0;
            mode_s1_reg <= MODE_BARS;
            bar_s1_reg  <= '0;
            grid_s1_reg <= 1'b0;
            box_s1_reg  <= 1'b0;
            grad_s1_reg <= '0;
        end else begin
            hs_s1_reg   <= lcd.HSYNC_IN;
            vs_s1_reg   <= lcd.VSYNC_IN;
            de_s1_reg   <= lcd.DEN_IN;
            mode_s1_reg <= mode_reg;
            bar_s1_reg  <= bar_idx;
            grid_s1_reg <= grid_hit;
            box_s1_reg  <= box_hit;
            grad_s1_reg <= {lcd.X_IN[8:4], lcd.Y_IN[8:3], frame_cnt_reg[4:0]};
        end
    end

    rgb565_t pix;

    always_comb begin
        case (mode_s1_reg)
            MODE_BARS: pix = bar_colour(bar_s1_reg);
            MODE_GRID: pix = grid_s1_reg ? WHITE : BLACK;
            MODE_GRAD: pix = grad_s1_reg;
            default:   pix = box_s1_reg ? RED : BLUE;
        endcase
        if (!de_s1_reg) begin
            pix = BLACK;
        end
    end

    logic    hs_s2_reg, vs_s2_reg, de_s2_reg;
    rgb565_t rgb_s2_reg;

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            hs_s2_reg  <= 1'b1;
            vs_s2_reg  <= 1'b1;
            de_s2_reg  <= 1'b0;
            rgb_s2_reg <= BLACK;
        end else begin
            hs_s2_reg  <= hs_s1_reg;
            vs_s2_reg  <= vs_s1_reg;
            de_s2_reg  <= de_s1_reg;
            rgb_s2_reg <= pix;
        end
    end

    assign lcd.LCD_HSYNC = hs_s2_reg;
    assign lcd.LCD_VSYNC = vs_s2_reg;
    assign lcd.LCD_DEN   = de_s2_reg;
    assign lcd.LCD_R     = rgb_s2_reg[15:11];
    assign lcd.LCD_G     = rgb_s2_reg[10:5];
    assign lcd.LCD_B     = rgb_s2_reg[4:0];

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench: three generator instances share the timing stimulus
// (main 480x280, auto-rotating, and a small 64x40 bouncing-box panel).
module tb_lcd_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        hs, vs, de;
    logic [10:0] x_s, y_s;
    logic        btn_a, btn_c;

    int checks;
    int errors;
    int ticks;

    lcd_pattern_gen_if if_a ();
    lcd_pattern_gen_if if_b ();
    lcd_pattern_gen_if if_c ();

    assign if_a.HSYNC_IN = hs;  assign if_a.VSYNC_IN = vs;  assign if_a.DEN_IN = de;
    assign if_a.X_IN     = x_s; assign if_a.Y_IN     = y_s;
    assign if_b.HSYNC_IN = hs;  assign if_b.VSYNC_IN = vs;  assign if_b.DEN_IN = de;
    assign if_b.X_IN     = x_s; assign if_b.Y_IN     = y_s;
    assign if_c.HSYNC_IN = hs;  assign if_c.VSYNC_IN = vs;  assign if_c.DEN_IN = de;
    assign if_c.X_IN     = x_s; assign if_c.Y_IN     = y_s;

    lcd_pattern_gen #(
        .AUTO_FRAMES(0), .DEBOUNCE_CYCLES(4)
    ) dut_a (
        .CLK(clk), .RST_IN(rst_n), .BTN_N(btn_a), .lcd(if_a)
    );

    lcd_pattern_gen #(
        .AUTO_FRAMES(2), .DEBOUNCE_CYCLES(4)
    ) dut_b (
        .CLK(clk), .RST_IN(rst_n), .BTN_N(1'b1), .lcd(if_b)
    );

    lcd_pattern_gen #(
        .LCD_WIDTH(64), .LCD_HEIGHT(40), .BOX_SIZE(8), .AUTO_FRAMES(0), .DEBOUNCE_CYCLES(4)
    ) dut_c (
        .CLK(clk), .RST_IN(rst_n), .BTN_N(btn_c), .lcd(if_c)
    );

    wire [15:0] rgb_a = {if_a.LCD_R, if_a.LCD_G, if_a.LCD_B};
    wire [15:0] rgb_c = {if_c.LCD_R, if_c.LCD_G, if_c.LCD_B};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic apply(input logic [10:0] xv, input logic [10:0] yv, input logic dv);
        @(negedge clk);
        hs = 1'b1; vs = 1'b1; de = dv; x_s = xv; y_s = yv;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic frame_tick();
        @(negedge clk);
        de = 1'b0; vs = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vs = 1'b1;
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic press(input bit on_c, input int len);
        @(negedge clk);
        if (on_c) btn_c = 1'b0; else btn_a = 1'b0;
        repeat (len) @(negedge clk);
        if (on_c) btn_c = 1'b1; else btn_a = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    logic [10:0] bar_x   [12] = '{11'd0, 11'd59, 11'd60, 11'd119, 11'd120, 11'd180,
                                  11'd240, 11'd300, 11'd360, 11'd419, 11'd420, 11'd479};
    logic [15:0] bar_exp [12] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07E0,
                                  16'hF81F, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000};
    logic [1:0]  auto_exp [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        hs = 1'b1; vs = 1'b1; de = 1'b0; x_s = '0; y_s = '0;
        btn_a = 1'b1; btn_c = 1'b1;
        checks = 0; errors = 0; ticks = 0;

        // Inputs toggle while reset is held
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hs = i[0]; vs = ~i[0]; de = i[0]; x_s = 11'(i * 37); btn_a = i[1];
        end
        @(negedge clk);
        chk("rst_hsync", 16'(if_a.LCD_HSYNC), 16'h1);
        chk("rst_vsync", 16'(if_a.LCD_VSYNC), 16'h1);
        chk("rst_den",   16'(if_a.LCD_DEN),   16'h0);
        chk("rst_rgb",   rgb_a,               16'h0000);
        chk("rst_mode",  16'(if_a.MODE),      16'h0);

        rst_n = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b1; x_s = '0; y_s = '0; btn_a = 1'b1;
        @(posedge clk); #1;
        chk("lat1_den", 16'(if_a.LCD_DEN), 16'h0);
        @(posedge clk); #1;
        chk("lat2_den", 16'(if_a.LCD_DEN), 16'h1);
        chk("lat2_rgb", rgb_a,             16'hFFFF);

        for (int i = 0; i < 12; i++) begin
            apply(bar_x[i], 11'd10, 1'b1);
            chk($sformatf("bars_x%0d", bar_x[i]), rgb_a, bar_exp[i]);
        end
        apply(11'd0, 11'd10, 1'b0);
        chk("bars_den0_rgb", rgb_a, 16'h0000);
        chk("bars_den0_den", 16'(if_a.LCD_DEN), 16'h0);

        @(negedge clk);
        hs = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("hsync_pass", 16'(if_a.LCD_HSYNC), 16'h0);
        chk("vsync_pass", 16'(if_a.LCD_VSYNC), 16'h1);

        for (int f = 0; f < 8; f++) begin
            chk($sformatf("auto_f%0d", f), 16'(if_b.MODE), 16'(auto_exp[f]));
            frame_tick();
        end
        chk("auto_wrap", 16'(if_b.MODE), 16'(auto_exp[8]));
        chk("auto_off",  16'(if_a.MODE), 16'h0);

        press(1'b0, 3);
        frame_tick();
        chk("glitch_mode", 16'(if_a.MODE), 16'h0);

        press(1'b0, 10);
        chk("press_pre_tick", 16'(if_a.MODE), 16'h0);
        frame_tick();
        chk("press_tick", 16'(if_a.MODE), 16'h1);

        apply(11'd32, 11'd5, 1'b1);    chk("grid_32_5",    rgb_a, 16'hFFFF);
        apply(11'd7, 11'd64, 1'b1);    chk("grid_7_64",    rgb_a, 16'hFFFF);
        apply(11'd479, 11'd100, 1'b1); chk("grid_479_100", rgb_a, 16'hFFFF);
        apply(11'd33, 11'd33, 1'b1);   chk("grid_33_33",   rgb_a, 16'h0000);
        apply(11'd100, 11'd279, 1'b1); chk("grid_100_279", rgb_a, 16'hFFFF);
        apply(11'd100, 11'd278, 1'b1); chk("grid_100_278", rgb_a, 16'h0000);

        press(1'b0, 10);
        press(1'b0, 10);
        frame_tick();
        chk("two_press", 16'(if_a.MODE), 16'h2);
        frame_tick();
        chk("two_press_hold", 16'(if_a.MODE), 16'h2);

        // Gradient: R=X[8:4], G=Y[8:3], B=frames ticked since reset
        apply(11'd479, 11'd200, 1'b1);
        chk("grad_479_200", rgb_a, {5'd29, 6'd25, 5'(ticks)});
        apply(11'd16, 11'd8, 1'b1);
        chk("grad_16_8", rgb_a, {5'd1, 6'd1, 5'(ticks)});

        for (int p = 0; p < 3; p++) begin
            press(1'b1, 10);
            frame_tick();
        end
        chk("bounce_mode", 16'(if_c.MODE), 16'h3);

        while (ticks < 55) frame_tick();
        // Box at (55,7) after 55 ticks
        apply(11'd55, 11'd7, 1'b1);  chk("box_55_7",  rgb_c, 16'hF800);
        apply(11'd63, 11'd7, 1'b1);  chk("box_63_7",  rgb_c, 16'h001F);
        apply(11'd54, 11'd7, 1'b1);  chk("box_54_7",  rgb_c, 16'h001F);
        apply(11'd62, 11'd14, 1'b1); chk("box_62_14", rgb_c, 16'hF800);
        apply(11'd62, 11'd15, 1'b1); chk("box_62_15", rgb_c, 16'h001F);
        apply(11'd0, 11'd0, 1'b1);   chk("grad_tick55", rgb_a, 16'h0017);

        frame_tick();
        // X reversed at the wall; box now at (54,6)
        apply(11'd54, 11'd6, 1'b1);  chk("box_54_6",  rgb_c, 16'hF800);
        apply(11'd53, 11'd6, 1'b1);  chk("box_53_6",  rgb_c, 16'h001F);
        apply(11'd61, 11'd13, 1'b1); chk("box_61_13", rgb_c, 16'hF800);
        apply(11'd62, 11'd6, 1'b1);  chk("box_62_6",  rgb_c, 16'h001F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
